auth_tx_serializer: RTL

Transmit stage downstream of the authentication driver. It takes one complete authentication message, MSG_LEN bits wide, from the driver's parallel output and confirms acceptance with a one-cycle acknowledge. It then serializes the message onto the differential TX2_p/TX2_m pair, adding a preamble and an end-of-packet. Transmission is gated by Type-C attach and orientation, decoded from the CC1/CC2 lines.

---
 rtl/auth_tx_serializer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/auth_tx_serializer.sv
// auth_tx_serializer
//   Accepts one MSG_LEN-bit authentication message from the driver and sends
//   it on the differential TX2 pair as: alternating preamble (1,0,1,...),
//   the message MSB first, then a two bit-time end-of-packet with both legs 0.
//   Transmission is allowed only while the Type-C CC lines show an attach in
//   the same orientation that was seen when the message was accepted.
//
// Ports
//   clk, reset        system clock; asynchronous active-low reset
//   msg_valid/data    message offer from the driver (held until msg_ack)
//   msg_ack           one-cycle pulse when the message is latched
//   CC1, CC2          configuration channel lines, asynchronous to clk
//   TX2_p, TX2_m      differential line; both 0 when idle or in EOP
//   tx_busy           high from acceptance until back in IDLE
//   tx_done           one-cycle pulse after the last EOP cycle
//   orient_err        one-cycle pulse: request refused or frame aborted

module auth_tx_serializer #(
    parameter int MSG_LEN       = 2080,
    parameter int CLK_DIV       = 4,
    parameter int PREAMBLE_BITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               msg_valid,
    input  logic [MSG_LEN-1:0] msg_data,
    output logic               msg_ack,
    input  logic               CC1,
    input  logic               CC2,
    output logic               TX2_p,
    output logic               TX2_m,
    output logic               tx_busy,
    output logic               tx_done,
    output logic               orient_err
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int PW = $clog2(PREAMBLE_BITS) + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(MSG_LEN - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BITS - 1);
    localparam logic [BW-1:0] EOP_LAST = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_EOP
    } state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]      pre_cnt_q, pre_cnt_d;
    logic [MSG_LEN-1:0] shreg_q, shreg_d;
    logic [1:0]         orient_q, orient_d;
    logic               txp_q, txp_d;
    logic               txm_q, txm_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               oerr_q, oerr_d;

    // Two-flop synchronizer for the CC pair, packed as {CC1, CC2}
    logic [1:0] cc_meta_q, cc_s_q;

    logic attached;
    logic div_wrap;

    assign attached = cc_s_q[1] ^ cc_s_q[0];
    assign div_wrap = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        pre_cnt_d = pre_cnt_q;
        shreg_d   = shreg_q;
        orient_d  = orient_q;
        txp_d     = txp_q;
        txm_d     = txm_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        oerr_d    = 1'b0;

        if (state_q == S_IDLE) begin
            div_d = '0;
            if (msg_valid) begin
                if (attached) begin
                    shreg_d   = msg_data;
                    orient_d  = cc_s_q;
                    ack_d     = 1'b1;
                    busy_d    = 1'b1;
                    pre_cnt_d = '0;
                    bit_cnt_d = '0;
                    // First preamble bit goes out together with the ack
                    txp_d     = 1'b1;
                    txm_d     = 1'b0;
                    state_d   = S_PRE;
                end else begin
                    oerr_d = 1'b1;
                end
            end
        end else if (cc_s_q != orient_q) begin
            // Detach, both-high or flip: drop the frame, no tx_done.
            // Takes priority over the EOP completion on the same cycle.
            state_d   = S_IDLE;
            div_d     = '0;
            bit_cnt_d = '0;
            pre_cnt_d = '0;
            shreg_d   = '0;
            txp_d     = 1'b0;
            txm_d     = 1'b0;
            busy_d    = 1'b0;
            oerr_d    = 1'b1;
        end else begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
            if (div_wrap) begin
                case (state_q)
                    S_PRE: begin
                        if (pre_cnt_q == PRE_LAST) begin
                            pre_cnt_d = '0;
                            txp_d     = shreg_q[MSG_LEN-1];
                            txm_d     = ~shreg_q[MSG_LEN-1];
                            state_d   = S_DATA;
                        end else begin
                            // Even preamble index -> 1, odd -> 0
                            pre_cnt_d = pre_cnt_q + 1'b1;
                            txp_d     = ~pre_cnt_d[0];
                            txm_d     = pre_cnt_d[0];
                        end
                    end
                    S_DATA: begin
                        shreg_d = shreg_q << 1;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            txp_d     = 1'b0;
                            txm_d     = 1'b0;
                            state_d   = S_EOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            txp_d     = shreg_d[MSG_LEN-1];
                            txm_d     = ~shreg_d[MSG_LEN-1];
                        end
                    end
                    S_EOP: begin
                        // bit counter reused to time the two EOP bit-times
                        if (bit_cnt_q == EOP_LAST) begin
                            bit_cnt_d = '0;
                            done_d    = 1'b1;
                            busy_d    = 1'b0;
                            state_d   = S_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            pre_cnt_q <= '0;
            shreg_q   <= '0;
            orient_q  <= '0;
            txp_q     <= 1'b0;
            txm_q     <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            oerr_q    <= 1'b0;
            cc_meta_q <= '0;
            cc_s_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            pre_cnt_q <= pre_cnt_d;
            shreg_q   <= shreg_d;
            orient_q  <= orient_d;
            txp_q     <= txp_d;
            txm_q     <= txm_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            oerr_q    <= oerr_d;
            cc_meta_q <= {CC1, CC2};
            cc_s_q    <= cc_meta_q;
        end
    end

    assign msg_ack    = ack_q;
    assign TX2_p      = txp_q;
    assign TX2_m      = txm_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign orient_err = oerr_q;

endmodule
